// File: rtl/uart_rx_cmd_ctrl.sv
// uart_rx_cmd_ctrl: turns the UART receiver's byte stream into HEADER/ADDR/DATA/CSUM command frames.
// An inter-byte timeout is compiled in only when UART_CMD_TIMEOUT_EN is defined.
module uart_rx_cmd_ctrl #(
  parameter logic [7:0] HEADER       = 8'hA5,
  parameter int         CLOCK_FREQ   = 50_000_000,
  parameter int         BAUD         = 9600,
  parameter int         TIMEOUT_BITS = 20,
  parameter int         TIMEOUT_CLKS = CLOCK_FREQ / BAUD * TIMEOUT_BITS
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [7:0] Rx_Data,
  input  logic       Rx_Done,
  output logic       Wr_En,
  output logic [7:0] Wr_Addr,
  output logic [7:0] Wr_Data,
  output logic       Pkt_Err,
  output logic [7:0] Err_Cnt,
  output logic       Busy
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_CSUM} state_t;

  state_t     state;
  state_t     next_state;
  logic [7:0] addr_q;
  logic [7:0] data_q;
  logic [7:0] csum_exp;
  logic       accept;
  logic       csum_err;
  logic       frame_err;
  logic       latch_addr;
  logic       latch_data;
  logic       timeout;

  assign csum_exp = addr_q + data_q;
  assign Busy     = (state != S_IDLE);

`ifdef UART_CMD_TIMEOUT_EN
  localparam int            TW         = $clog2(TIMEOUT_CLKS + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CLKS - 1);

  logic [TW-1:0] timer;

  // A byte arriving on the expiry cycle wins, so Rx_Done masks the timeout.
  assign timeout = Busy && !Rx_Done && (timer == TIMER_LAST);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      timer <= '0;
    end else if (Rx_Done || !Busy || timeout) begin
      timer <= '0;
    end else begin
      timer <= timer + TW'(1);
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign frame_err = csum_err || timeout;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= S_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    accept     = 1'b0;
    csum_err   = 1'b0;
    latch_addr = 1'b0;
    latch_data = 1'b0;
    if (Rx_Done) begin
      case (state)
        S_IDLE: begin
          if (Rx_Data == HEADER) begin
            next_state = S_ADDR;
          end
        end
        S_ADDR: begin
          latch_addr = 1'b1;
          next_state = S_DATA;
        end
        S_DATA: begin
          latch_data = 1'b1;
          next_state = S_CSUM;
        end
        S_CSUM: begin
          next_state = S_IDLE;
          if (Rx_Data == csum_exp) begin
            accept = 1'b1;
          end else begin
            csum_err = 1'b1;
          end
        end
        default: next_state = S_IDLE;
      endcase
    end else if (timeout) begin
      next_state = S_IDLE;
    end
  end

  // Bad frames only touch Pkt_Err/Err_Cnt; the write port keeps its last good frame.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Wr_En   <= 1'b0;
      Wr_Addr <= 8'h00;
      Wr_Data <= 8'h00;
      Pkt_Err <= 1'b0;
      Err_Cnt <= 8'h00;
      addr_q  <= 8'h00;
      data_q  <= 8'h00;
    end else begin
      Wr_En   <= accept;
      Pkt_Err <= frame_err;
      if (latch_addr) begin
        addr_q <= Rx_Data;
      end
      if (latch_data) begin
        data_q <= Rx_Data;
      end
      if (accept) begin
        Wr_Addr <= addr_q;
        Wr_Data <= data_q;
      end
      if (frame_err && (Err_Cnt != 8'hFF)) begin
        Err_Cnt <= Err_Cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_cmd_ctrl.sv
// tb_uart_rx_cmd_ctrl: directed frame scenarios plus random byte traffic checked every cycle
// against a queue-based frame model; follows UART_CMD_TIMEOUT_EN the same way the design does.
module tb_uart_rx_cmd_ctrl;

  localparam int         TO  = 100;
  localparam logic [7:0] HDR = 8'hA5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rx_done = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       pkt_err;
  logic [7:0] err_cnt;
  logic       busy;

  always #5 clk = ~clk;

  uart_rx_cmd_ctrl #(.TIMEOUT_CLKS(TO)) dut (
    .Clk(clk), .Reset(reset), .Rx_Data(rx_data), .Rx_Done(rx_done),
    .Wr_En(wr_en), .Wr_Addr(wr_addr), .Wr_Data(wr_data),
    .Pkt_Err(pkt_err), .Err_Cnt(err_cnt), .Busy(busy)
  );

  int total = 0;
  int bad = 0;
  int wr_pulses = 0;
  int err_pulses = 0;

  // Reference model: bytes of the frame collected so far, plus expected outputs after the next edge.
  logic [7:0] frame_q[$];
  int         gap = 0;
  bit         model_ready = 1'b0;
  logic       exp_wr = 1'b0;
  logic       exp_err = 1'b0;
  logic [7:0] exp_addr = 8'h00;
  logic [7:0] exp_data = 8'h00;
  logic [7:0] exp_cnt = 8'h00;
  logic       exp_busy = 1'b0;

  task automatic model_error();
    exp_err = 1'b1;
    if (exp_cnt != 8'hFF) exp_cnt = exp_cnt + 8'd1;
  endtask

  task automatic model_step();
    if (reset) begin
      frame_q.delete();
      gap = 0;
      model_ready = 1'b1;
      exp_wr = 0; exp_err = 0; exp_addr = 0; exp_data = 0; exp_cnt = 0;
    end else begin
      exp_wr = 1'b0;
      exp_err = 1'b0;
      if (rx_done) begin
        gap = 0;
        if (frame_q.size() == 0) begin
          if (rx_data == HDR) frame_q.push_back(rx_data);
        end else begin
          frame_q.push_back(rx_data);
          if (frame_q.size() == 4) begin
            if ((int'(frame_q[1]) + int'(frame_q[2])) % 256 == int'(frame_q[3])) begin
              exp_wr = 1'b1;
              exp_addr = frame_q[1];
              exp_data = frame_q[2];
            end else begin
              model_error();
            end
            frame_q.delete();
          end
        end
      end else if (frame_q.size() != 0) begin
        gap++;
`ifdef UART_CMD_TIMEOUT_EN
        if (gap == TO) begin
          model_error();
          frame_q.delete();
          gap = 0;
        end
`endif
      end
    end
    exp_busy = (frame_q.size() != 0);
  endtask

  // One clock: compare on the falling edge, advance the model, then step past the rising edge.
  task automatic cycle();
    @(negedge clk);
    if (model_ready) begin
      total++;
      if ({wr_en, pkt_err, wr_addr, wr_data, err_cnt, busy} !==
          {exp_wr, exp_err, exp_addr, exp_data, exp_cnt, exp_busy}) begin
        bad++;
        $display("[TB] FAIL cycle_cmp t=%0t got en=%b err=%b a=%h d=%h cnt=%h busy=%b want en=%b err=%b a=%h d=%h cnt=%h busy=%b",
                 $time, wr_en, pkt_err, wr_addr, wr_data, err_cnt, busy,
                 exp_wr, exp_err, exp_addr, exp_data, exp_cnt, exp_busy);
      end
    end
    if (wr_en === 1'b1) wr_pulses++;
    if (pkt_err === 1'b1) err_pulses++;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("[TB] FAIL %s got %h want %h", name, act, want);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap_clks);
    rx_data = b;
    rx_done = 1'b1;
    cycle();
    rx_done = 1'b0;
    rx_data = 8'($urandom);
    idle(gap_clks);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] d, input logic [7:0] c, input int g);
    send_byte(HDR, g);
    send_byte(a, g);
    send_byte(d, g);
    send_byte(c, g);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
  endtask

  int w0;
  int e0;
  logic [7:0] ra;
  logic [7:0] rd;
  logic [7:0] rc;

  initial begin
    reset = 1'b1;
    cycle();
    cycle();
    reset = 1'b0;
    check_lit("reset_outputs", {wr_en, pkt_err, wr_addr, wr_data, err_cnt, busy}, 32'h0);

    // Good frame, with the write strobe pinned to one clock after the CSUM strobe.
    send_byte(HDR, 10);
    send_byte(8'h12, 10);
    send_byte(8'h34, 10);
    send_byte(8'h46, 0);
    check_lit("t1_wr_en", wr_en, 1);
    check_lit("t1_addr_data", {wr_addr, wr_data}, 16'h1234);
    cycle();
    check_lit("t1_wr_en_drop", wr_en, 0);
    idle(10);
    check_lit("t1_err", {pkt_err, err_cnt}, 0);

    send_frame(8'hF0, 8'h20, 8'h10, 10);
    check_lit("t2_wrap_write", {wr_addr, wr_data}, 16'hF020);
    e0 = err_pulses;
    send_frame(8'h01, 8'h02, 8'h04, 10);
    check_lit("t2_bad_pulse", err_pulses - e0, 1);
    check_lit("t2_bad_cnt", err_cnt, 1);
    check_lit("t2_hold", {wr_addr, wr_data}, 16'hF020);

    w0 = wr_pulses;
    send_byte(8'h00, 10); send_byte(8'hFF, 10); send_byte(8'hA5, 10);
    send_byte(8'hA5, 10); send_byte(8'h05, 10); send_byte(8'hAA, 10);
    check_lit("t3_one_write", wr_pulses - w0, 1);
    check_lit("t3_addr_data", {wr_addr, wr_data}, 16'hA505);

    e0 = err_pulses;
    send_byte(HDR, 10);
    send_byte(8'h10, 0);
`ifdef UART_CMD_TIMEOUT_EN
    idle(99);
    check_lit("t4_before_expiry", {pkt_err, busy}, 2'b01);
    cycle();
    check_lit("t4_expiry", {pkt_err, busy}, 2'b10);
    check_lit("t4_cnt", err_cnt, 2);
    idle(50);
    send_frame(8'h01, 8'h01, 8'h02, 10);
    check_lit("t4_after_write", {wr_addr, wr_data}, 16'h0101);
`else
    idle(150);
    check_lit("t4_no_timeout", err_pulses - e0, 0);
    check_lit("t4_still_busy", busy, 1);
    send_frame(8'h01, 8'h01, 8'h02, 10);
    check_lit("t4_header_as_data", err_cnt, 2);
    check_lit("t4_hold", {wr_addr, wr_data}, 16'hA505);
`endif

    send_byte(HDR, 10);
    send_byte(8'h33, 10);
    check_lit("t5_busy_mid", busy, 1);
    pulse_reset();
    check_lit("t5_reset_outputs", {wr_en, pkt_err, wr_addr, wr_data, err_cnt, busy}, 32'h0);
    send_frame(8'h33, 8'h44, 8'h77, 10);
    check_lit("t5_write", {wr_addr, wr_data}, 16'h3344);

    e0 = err_pulses;
    repeat (260) begin
      ra = 8'($urandom);
      rd = 8'($urandom);
      rc = ra + rd + 8'($urandom_range(1, 255));
      send_frame(ra, rd, rc, 10);
    end
    check_lit("t6_saturated", err_cnt, 8'hFF);
    check_lit("t6_pulses", err_pulses - e0, 260);
    check_lit("t6_hold", {wr_addr, wr_data}, 16'h3344);

    // Random traffic: good/bad frames, stray bytes, long silences and resets, any spacing.
    pulse_reset();
    for (int i = 0; i < 400; i++) begin
      int kind;
      kind = $urandom_range(0, 99);
      ra = 8'($urandom);
      rd = 8'($urandom);
      if (kind < 60) begin
        send_frame(ra, rd, ra + rd, $urandom_range(0, 12));
      end else if (kind < 80) begin
        send_frame(ra, rd, ra + rd + 8'($urandom_range(1, 255)), $urandom_range(0, 12));
      end else if (kind < 90) begin
        send_byte(($urandom_range(0, 3) == 0) ? HDR : ra, $urandom_range(0, 8));
      end else if (kind < 96) begin
        idle($urandom_range(95, 130));
      end else begin
        pulse_reset();
      end
    end
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
